wash_sequencer: RTL and testbench



---
 rtl/wash_sequencer.sv | 157 +++++++++++++++
 tb/tb_wash_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Wash sequencer: a single run is FILL -> SHAKE -> TURN, repeated for
// 1 + rinse_cnt passes. A FILL that takes too long drops into FAULT
// until clear. Pause freezes the running sequence and its actuators.
module wash_sequencer #(
    parameter int CNT_W = 16,
    parameter int RIN_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             full,
    input  logic             dry,
    input  logic [CNT_W-1:0] shake_time,
    input  logic [CNT_W-1:0] fill_timeout,
    input  logic [RIN_W-1:0] rinse_cnt,
    output logic             valve,
    output logic             shake_mode,
    output logic             turn_mode,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [RIN_W-1:0] cycle_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SHAKE,
        S_TURN,
        S_FAULT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [RIN_W-1:0] RIN_ONE = RIN_W'(1);

    state_e           state_q,       state_d;
    logic [CNT_W-1:0] timer_q,       timer_d;
    logic [RIN_W-1:0] idx_q,         idx_d;
    logic [CNT_W-1:0] shake_cfg_q,   shake_cfg_d;
    logic [CNT_W-1:0] timeout_cfg_q, timeout_cfg_d;
    logic [RIN_W-1:0] rinse_cfg_q,   rinse_cfg_d;
    logic             done_q,        done_d;

    logic [CNT_W-1:0] timer_inc;
    logic [CNT_W-1:0] shake_last;
    logic             fill_expired;

    // Timer step that sticks at all-ones instead of wrapping to zero.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + CNT_ONE;

    // A zero shake duration still shakes for one cycle.
    assign shake_last = (shake_cfg_q == '0) ? '0 : shake_cfg_q - CNT_ONE;

    // Timeout fires on the last permitted FILL cycle; zero disables it.
    assign fill_expired = (timeout_cfg_q != '0) && (timer_q == timeout_cfg_q - CNT_ONE);

    // Next-state, timer, pass index and configuration latch.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        timer_d       = timer_q;
        idx_d         = idx_q;
        shake_cfg_d   = shake_cfg_q;
        timeout_cfg_d = timeout_cfg_q;
        rinse_cfg_d   = rinse_cfg_q;
        done_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    shake_cfg_d   = shake_time;
                    timeout_cfg_d = fill_timeout;
                    rinse_cfg_d   = rinse_cnt;
                    timer_d       = '0;
                    idx_d         = '0;
                    state_d       = S_FILL;
                end
            end
            S_FILL: begin
                if (!pause) begin
                    // full has priority over a timeout on the same cycle
                    if (full) begin
                        timer_d = '0;
                        state_d = S_SHAKE;
                    end else if (fill_expired) begin
                        timer_d = '0;
                        state_d = S_FAULT;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end
            S_SHAKE: begin
                if (!pause) begin
                    if (timer_q == shake_last) begin
                        timer_d = '0;
                        state_d = S_TURN;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end
            S_TURN: begin
                if (!pause && dry) begin
                    if (idx_q == rinse_cfg_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + RIN_ONE;
                        timer_d = '0;
                        state_d = S_FILL;
                    end
                end
            end
            S_FAULT: begin
                if (clear) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with asynchronous clear of the whole run context.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            idx_q         <= '0;
            shake_cfg_q   <= '0;
            timeout_cfg_q <= '0;
            rinse_cfg_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q       <= state_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            shake_cfg_q   <= shake_cfg_d;
            timeout_cfg_q <= timeout_cfg_d;
            rinse_cfg_q   <= rinse_cfg_d;
            done_q        <= done_d;
        end
    end

    assign valve      = (state_q == S_FILL)  && !pause;
    assign shake_mode = (state_q == S_SHAKE) && !pause;
    assign turn_mode  = (state_q == S_TURN)  && !pause;
    assign busy       = (state_q == S_FILL) || (state_q == S_SHAKE) || (state_q == S_TURN);
    assign fault      = (state_q == S_FAULT);
    assign done       = done_q;
    assign cycle_idx  = idx_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed tables and sequences for the
// documented scenarios, then random stimulus against a behavioural model.
module tb_wash_sequencer;

    localparam int CNT_W = 16;
    localparam int RIN_W = 3;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start, pause, clear, full, dry;
    logic [CNT_W-1:0] shake_time, fill_timeout;
    logic [RIN_W-1:0] rinse_cnt;
    logic             valve, shake_mode, turn_mode, busy, done, fault;
    logic [RIN_W-1:0] cycle_idx;

    int n_checks = 0;
    int n_fail   = 0;

    wash_sequencer #(.CNT_W(CNT_W), .RIN_W(RIN_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .pause       (pause),
        .clear       (clear),
        .full        (full),
        .dry         (dry),
        .shake_time  (shake_time),
        .fill_timeout(fill_timeout),
        .rinse_cnt   (rinse_cnt),
        .valve       (valve),
        .shake_mode  (shake_mode),
        .turn_mode   (turn_mode),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .cycle_idx   (cycle_idx)
    );

    always #5 clock = ~clock;

    // Output vector layout: {valve, shake, turn, busy, done, fault, idx[2:0]}
    typedef struct {
        logic       st, pa, cl, fu, dr;
        logic [8:0] exp;
    } vec_t;

    vec_t basic[12];

    function automatic logic [8:0] outs();
        return {valve, shake_mode, turn_mode, busy, done, fault, cycle_idx};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs for one cycle and move to the sampling point.
    task automatic drive(input logic s, input logic p, input logic c, input logic f, input logic d);
        start = s; pause = p; clear = c; full = f; dry = d;
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic run_basic(input string tag);
        shake_time = 4; fill_timeout = 0; rinse_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(basic[i].st, basic[i].pa, basic[i].cl, basic[i].fu, basic[i].dr);
            check($sformatf("%s_step%0d", tag, i), outs(), basic[i].exp);
            adv();
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_FILL = 1, M_SHAKE = 2, M_TURN = 3, M_FAULT = 4;
    int m_mode, m_el, m_pass, m_shake, m_to, m_rinse;
    bit m_done;

    task automatic model_reset();
        m_mode = M_IDLE; m_el = 0; m_pass = 0;
        m_shake = 0; m_to = 0; m_rinse = 0; m_done = 0;
    endtask

    function automatic logic [8:0] model_out(input logic p);
        int v;
        v = 0;
        if (m_mode == M_FILL  && !p) v += 256;
        if (m_mode == M_SHAKE && !p) v += 128;
        if (m_mode == M_TURN  && !p) v += 64;
        if (m_mode == M_FILL || m_mode == M_SHAKE || m_mode == M_TURN) v += 32;
        if (m_done) v += 16;
        if (m_mode == M_FAULT) v += 8;
        v += m_pass;
        return v[8:0];
    endfunction

    task automatic model_step(input logic s, input logic p, input logic c, input logic f, input logic d,
                              input int sh, input int to, input int rn);
        int shake_len;
        m_done = 0;
        shake_len = (m_shake == 0) ? 1 : m_shake;
        case (m_mode)
            M_IDLE: if (s) begin
                m_shake = sh; m_to = to; m_rinse = rn;
                m_el = 0; m_pass = 0; m_mode = M_FILL;
            end
            M_FAULT: if (c) m_mode = M_IDLE;
            M_FILL: if (!p) begin
                if (f) begin m_mode = M_SHAKE; m_el = 0; end
                else if (m_to != 0 && m_el + 1 == m_to) m_mode = M_FAULT;
                else m_el++;
            end
            M_SHAKE: if (!p) begin
                if (m_el + 1 >= shake_len) begin m_mode = M_TURN; m_el = 0; end
                else m_el++;
            end
            M_TURN: if (!p && d) begin
                if (m_pass == m_rinse) begin m_mode = M_IDLE; m_done = 1; end
                else begin m_pass++; m_el = 0; m_mode = M_FILL; end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int shake_cnt;
        bit seen_turn;

        // basic run: full on the third FILL cycle, dry on the second TURN cycle
        basic[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000_000};
        basic[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b100100_000};
        basic[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b100100_000};
        basic[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b100100_000};
        basic[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b010100_000};
        basic[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b010100_000};
        basic[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b010100_000};
        basic[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b010100_000};
        basic[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b001100_000};
        basic[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b001100_000};
        basic[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000010_000};
        basic[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000_000};

        reset_n = 1'b0;
        start = 0; pause = 0; clear = 0; full = 0; dry = 0;
        shake_time = 0; fill_timeout = 0; rinse_cnt = 0;
        @(negedge clock);
        // inputs that would otherwise start or light outputs are held off by reset
        start = 1; pause = 1;
        #1;
        check("reset_outputs", outs(), 9'b0);
        start = 0; pause = 0;
        reset_n = 1'b1;
        adv();

        run_basic("basic");

        // three passes; config inputs changed mid-run must not matter
        shake_time = 1; fill_timeout = 0; rinse_cnt = 2;
        drive(1, 0, 0, 0, 0);
        check("multi_idle", outs(), 9'b0);
        adv();
        rinse_cnt = 0; shake_time = 7;
        for (int p = 0; p < 3; p++) begin
            drive(0, 0, 0, 1, 0);
            check($sformatf("multi_fill%0d", p), outs(), {6'b100100, 3'(p)});
            adv();
            drive(0, 0, 0, 0, 0);
            check($sformatf("multi_shake%0d", p), outs(), {6'b010100, 3'(p)});
            adv();
            drive(0, 0, 0, 0, 1);
            check($sformatf("multi_turn%0d", p), outs(), {6'b001100, 3'(p)});
            adv();
        end
        drive(0, 0, 0, 0, 0);
        check("multi_done", outs(), 9'b000010_010);
        adv();
        drive(0, 0, 0, 0, 0);
        check("multi_done_once", outs(), 9'b000000_010);
        adv();

        // fill timeout of 5 cycles, then FAULT ignores start and pause
        shake_time = 4; fill_timeout = 5; rinse_cnt = 0;
        drive(1, 0, 0, 0, 0);
        adv();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0);
            check($sformatf("timeout_fill%0d", i), outs(), 9'b100100_000);
            adv();
        end
        drive(1, 0, 0, 0, 0);
        check("fault_entered", outs(), 9'b000001_000);
        adv();
        drive(1, 1, 0, 0, 0);
        check("fault_ignores_start", outs(), 9'b000001_000);
        adv();
        drive(0, 0, 1, 0, 0);
        check("fault_before_clear", outs(), 9'b000001_000);
        adv();
        drive(0, 0, 0, 0, 0);
        check("fault_cleared", outs(), 9'b0);
        adv();

        // full and timeout on the same cycle; zero shake gives one cycle
        shake_time = 0; fill_timeout = 1; rinse_cnt = 0;
        drive(1, 0, 0, 0, 0);
        adv();
        drive(0, 0, 0, 1, 0);
        check("simul_fill", outs(), 9'b100100_000);
        adv();
        drive(0, 0, 0, 0, 0);
        check("full_beats_timeout", outs(), 9'b010100_000);
        adv();
        drive(0, 0, 0, 0, 1);
        check("shake0_one_cycle", outs(), 9'b001100_000);
        adv();
        drive(0, 0, 0, 0, 0);
        check("simul_done", outs(), 9'b000010_000);
        adv();
        // timeout of 1 without full: a single FILL cycle
        drive(1, 0, 0, 0, 0);
        adv();
        drive(0, 0, 0, 0, 0);
        check("timeout1_fill", outs(), 9'b100100_000);
        adv();
        drive(0, 0, 1, 0, 0);
        check("timeout1_fault", outs(), 9'b000001_000);
        adv();

        // pause for 3 cycles mid-SHAKE with sensors wiggling
        shake_time = 6; fill_timeout = 0; rinse_cnt = 0;
        drive(1, 0, 0, 0, 0);
        adv();
        drive(0, 0, 0, 1, 0);
        adv();
        shake_cnt = 0;
        seen_turn = 0;
        for (int k = 0; k < 30 && !seen_turn; k++) begin
            logic p;
            p = (k >= 2 && k < 5);
            drive(0, p, 0, p, p);
            if (p) check($sformatf("pause_shake%0d", k), outs(), 9'b000100_000);
            if (turn_mode) seen_turn = 1;
            else if (shake_mode) shake_cnt++;
            adv();
        end
        check("pause_reached_turn", 32'(seen_turn), 1);
        check("pause_shake_total", shake_cnt, 6);
        drive(0, 0, 0, 0, 1);
        adv();
        drive(0, 0, 0, 0, 0);
        check("pause_done", outs(), 9'b000010_000);
        adv();

        // reset during SHAKE of pass 1
        shake_time = 4; fill_timeout = 0; rinse_cnt = 2;
        drive(1, 0, 0, 0, 0);
        adv();
        drive(0, 0, 0, 1, 0);
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            adv();
        end
        drive(0, 0, 0, 0, 1);
        adv();
        drive(0, 0, 0, 1, 0);
        adv();
        drive(0, 0, 0, 0, 0);
        check("rst_pass1_shake", outs(), 9'b010100_001);
        reset_n = 1'b0;
        #1;
        check("rst_mid_run_async", outs(), 9'b0);
        adv();
        check("rst_mid_run_held", outs(), 9'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            check($sformatf("rst_no_done%0d", i), outs(), 9'b0);
            adv();
        end
        run_basic("after_rst");

        // random stimulus against the model, with occasional resets
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic s, p, c, f, d;
            int sh, to, rn;
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                #1;
                check($sformatf("rand_reset%0d", n), outs(), 9'b0);
                adv();
                reset_n = 1'b1;
                model_reset();
                continue;
            end
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 4) == 0);
            c  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 5) == 0);
            d  = ($urandom_range(0, 2) == 0);
            sh = $urandom_range(0, 5);
            to = $urandom_range(0, 8);
            rn = $urandom_range(0, 3);
            shake_time   = CNT_W'(sh);
            fill_timeout = CNT_W'(to);
            rinse_cnt    = RIN_W'(rn);
            drive(s, p, c, f, d);
            check($sformatf("rand%0d", n), outs(), model_out(p));
            adv();
            model_step(s, p, c, f, d, sh, to, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
